// File: rtl/rx_shift_sequencer.sv
// UART receive sequencer: finds the start bit, times each bit period and strobes the
// serial-to-parallel shift register at every data-bit centre, then qualifies the stop bit.
module rx_shift_sequencer #(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic serial_in,
  input  logic clear_error,
  output logic shift_enable,
  output logic load_buffer,
  output logic framing_error,
  output logic busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW = $clog2(DATA_BITS + 1);
  localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] NumBits = BitW'(DATA_BITS);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
  logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
  logic            prev_in_q, prev_in_d;
  logic            fe_q, fe_d;
  logic            at_half, at_last;

  assign at_half = (clk_cnt_q == HalfCnt);
  assign at_last = (clk_cnt_q == LastCnt);

  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    prev_in_d    = serial_in;
    fe_d         = fe_q;
    shift_enable = 1'b0;
    load_buffer  = 1'b0;

    if (state_q != StIdle) begin
      clk_cnt_d = at_last ? '0 : clk_cnt_q + 1'b1;
    end

    // Clear is applied first so a stop-bit error in the same cycle takes priority.
    if (clear_error) begin
      fe_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        clk_cnt_d = '0;
        if (prev_in_q && !serial_in) begin
          state_d   = StStart;
          clk_cnt_d = CntW'(1);
        end
      end
      StStart: begin
        if (at_half && serial_in) begin
          state_d   = StIdle;
          clk_cnt_d = '0;
        end else begin
          if (at_half) begin
            fe_d = 1'b0;
          end
          if (at_last) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
      end
      StData: begin
        if (at_half) begin
          shift_enable = 1'b1;
          bit_cnt_d    = bit_cnt_q + 1'b1;
        end
        if (at_last && (bit_cnt_q == NumBits)) begin
          state_d = StStop;
        end
      end
      StStop: begin
        // Leave at mid stop bit so the next start edge can be caught in its second half.
        if (at_half) begin
          load_buffer = serial_in;
          if (!serial_in) begin
            fe_d = 1'b1;
          end
          state_d   = StIdle;
          clk_cnt_d = '0;
        end
      end
      default: begin
        state_d   = StIdle;
        clk_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      prev_in_q <= 1'b1;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      prev_in_q <= prev_in_d;
      fe_q      <= fe_d;
    end
  end

  assign framing_error = fe_q;
  assign busy          = (state_q != StIdle);

endmodule
